// File: rtl/alu_sekwencer.sv
// alu_sekwencer: multi-cycle Rdst = Rdst op Rsrc unit driving a single-port register file.
// Latency: done in cycle T+4 after start at edge T (T+3+DATA_W for MUL when ALU_SEKWENCER_MUL_EN is defined).
// Backpressure: none; start is sampled only in IDLE and ignored while busy (no queue).
// Optional feature: define ALU_SEKWENCER_MUL_EN to enable opcode 8 as an iterative unsigned multiply.
module alu_sekwencer #(
   parameter int DATA_W    = 8,
   parameter int RX_LICZBA = 8,
   localparam int AW       = $clog2(RX_LICZBA)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        opcode,
   input  logic [AW-1:0]     nr_dst,
   input  logic [AW-1:0]     nr_src,
   input  logic [DATA_W-1:0] rx_out,
   output logic [AW-1:0]     rx_nr,
   output logic              rx_wr,
   output logic [DATA_W-1:0] rx_dane,
   output logic              busy,
   output logic              done,
   output logic              flag_z,
   output logic              flag_c,
   output logic              flag_n
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

   state_t            state;
   logic [3:0]        op_r;
   logic [AW-1:0]     dst_r;
   logic [AW-1:0]     src_r;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   // bit DATA_W carries the C flag value alongside the data result
   logic [DATA_W:0]   result_r;
   logic              upd_r;

   logic [DATA_W:0]   alu_res;
   logic              alu_wr;
   logic              alu_upd;

`ifdef ALU_SEKWENCER_MUL_EN
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   logic [2*DATA_W-1:0] mul_acc;
   logic [2*DATA_W-1:0] mul_next;
   logic [CW-1:0]       mul_cnt;
   logic                mul_last;

   // One shift-add step: add A shifted by the current bit position of B
   always_comb begin
      mul_next = mul_acc;
      if (b_r[mul_cnt])
         mul_next = mul_acc + ({{DATA_W{1'b0}}, a_r} << mul_cnt);
      mul_last = (mul_cnt == CW'(DATA_W - 1));
   end
`endif

   // Result, write enable and flag-update decision for the captured opcode
   always_comb begin
      alu_res = '0;
      alu_wr  = 1'b0;
      alu_upd = 1'b0;
      case (op_r)
         4'd0: begin alu_res = {1'b0, a_r} + {1'b0, b_r};            alu_wr = 1'b1; alu_upd = 1'b1; end
         4'd1: begin alu_res = {1'b0, a_r} - {1'b0, b_r};            alu_wr = 1'b1; alu_upd = 1'b1; end
         4'd2: begin alu_res = {1'b0, a_r & b_r};                    alu_wr = 1'b1; alu_upd = 1'b1; end
         4'd3: begin alu_res = {1'b0, a_r | b_r};                    alu_wr = 1'b1; alu_upd = 1'b1; end
         4'd4: begin alu_res = {1'b0, a_r ^ b_r};                    alu_wr = 1'b1; alu_upd = 1'b1; end
         4'd5: begin alu_res = {1'b0, b_r};                          alu_wr = 1'b1; alu_upd = 1'b1; end
         4'd6: begin alu_res = {a_r, 1'b0};                          alu_wr = 1'b1; alu_upd = 1'b1; end
         4'd7: begin alu_res = {a_r[0], 1'b0, a_r[DATA_W-1:1]};      alu_wr = 1'b1; alu_upd = 1'b1; end
`ifdef ALU_SEKWENCER_MUL_EN
         4'd8: begin
            alu_res = {|mul_next[2*DATA_W-1:DATA_W], mul_next[DATA_W-1:0]};
            alu_wr  = 1'b1;
            alu_upd = 1'b1;
         end
`endif
         // compare: subtract for flags only, no write-back
         4'd9: begin alu_res = {1'b0, a_r} - {1'b0, b_r};            alu_upd = 1'b1; end
         default: ;
      endcase
   end

   // Sequencer: operand reads, execute, write-back; all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_r     <= '0;
         dst_r    <= '0;
         src_r    <= '0;
         a_r      <= '0;
         b_r      <= '0;
         result_r <= '0;
         upd_r    <= 1'b0;
         rx_nr    <= '0;
         rx_wr    <= 1'b0;
         rx_dane  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
         flag_n   <= 1'b0;
`ifdef ALU_SEKWENCER_MUL_EN
         mul_acc  <= '0;
         mul_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_r  <= opcode;
                  dst_r <= nr_dst;
                  src_r <= nr_src;
                  rx_nr <= nr_dst;
                  busy  <= 1'b1;
                  state <= RD_A;
               end
            end
            RD_A: begin
               a_r   <= rx_out;
               rx_nr <= src_r;
               state <= RD_B;
            end
            RD_B: begin
               b_r   <= rx_out;
               rx_nr <= dst_r;
`ifdef ALU_SEKWENCER_MUL_EN
               mul_acc <= '0;
               mul_cnt <= '0;
`endif
               state <= EXEC;
            end
            EXEC: begin
`ifdef ALU_SEKWENCER_MUL_EN
               if (op_r == 4'd8 && !mul_last) begin
                  mul_acc <= mul_next;
                  mul_cnt <= mul_cnt + CW'(1);
               end else begin
                  result_r <= alu_res;
                  rx_dane  <= alu_res[DATA_W-1:0];
                  rx_wr    <= alu_wr;
                  upd_r    <= alu_upd;
                  done     <= 1'b1;
                  state    <= WB;
               end
`else
               result_r <= alu_res;
               rx_dane  <= alu_res[DATA_W-1:0];
               rx_wr    <= alu_wr;
               upd_r    <= alu_upd;
               done     <= 1'b1;
               state    <= WB;
`endif
            end
            WB: begin
               if (upd_r) begin
                  flag_z <= (result_r[DATA_W-1:0] == '0);
                  flag_c <= result_r[DATA_W];
                  flag_n <= result_r[DATA_W-1];
               end
               rx_wr <= 1'b0;
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
